// File: rtl/sm_controller.sv
// -----------------------------------------------------------------------------
// sm_controller
//   Control unit for the Simple RISC Machine datapath. It holds the
//   instruction register, decodes its fields, and sequences the datapath
//   load/select/write strobes through a multi-cycle Moore FSM.
//
// Parameters
//   DATA_W     : datapath width; sximm5/sximm8 are sign-extended to it (>= 16)
//   START_EDGE : 0 = start whenever s is high in WAIT,
//                1 = start only on a rising edge of s
//
// Optional feature
//   SM_ILLEGAL_TRAP_EN : when defined, an illegal instruction parks the FSM in
//                        TRAP (err = 1, w = 0) until reset. When undefined,
//                        an illegal instruction runs as a no-op and err pulses
//                        for the following WAIT cycle.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   s         in   start request
//   load      in   instruction register load enable (honoured only in WAIT)
//   in[15:0]  in   instruction word
//   w         out  idle in WAIT, ready for s
//   err       out  illegal-instruction flag
//   nsel[2:0] out  one-hot register select: 001 Rm, 010 Rd, 100 Rn
//   readnum   out  register-file read index
//   writenum  out  register-file write index
//   loada/loadb/loadc/loads  out  datapath register loads
//   asel/bsel out  ALU operand selects
//   vsel[1:0] out  write-back mux select (00 C, 10 sximm8)
//   write     out  register-file write enable
//   ALUop     out  ir[12:11]
//   shift     out  ir[4:3], forced to 00 for MOV immediate
//   sximm5    out  sign-extended ir[4:0]
//   sximm8    out  sign-extended ir[7:0]
// -----------------------------------------------------------------------------
module sm_controller #(
   parameter int DATA_W     = 16,
   parameter int START_EDGE = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s,
   input  logic              load,
   input  logic [15:0]       in,
   output logic              w,
   output logic              err,
   output logic [2:0]        nsel,
   output logic [2:0]        readnum,
   output logic [2:0]        writenum,
   output logic              loada,
   output logic              loadb,
   output logic              loadc,
   output logic              loads,
   output logic              asel,
   output logic              bsel,
   output logic [1:0]        vsel,
   output logic              write,
   output logic [1:0]        ALUop,
   output logic [1:0]        shift,
   output logic [DATA_W-1:0] sximm5,
   output logic [DATA_W-1:0] sximm8
);

   typedef enum logic [2:0] {
      ST_WAIT   = 3'd0,
      ST_DECODE = 3'd1,
      ST_GETA   = 3'd2,
      ST_GETB   = 3'd3,
      ST_EXEC   = 3'd4,
      ST_WREG   = 3'd5,
      ST_WIMM   = 3'd6,
      ST_TRAP   = 3'd7
   } state_t;

   typedef struct packed {
      logic       w;
      logic [2:0] nsel;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic [1:0] vsel;
      logic       write;
   } ctrl_t;

   // {opcode, op} codes
   localparam logic [4:0] CODE_MOV_IMM = 5'b110_10;
   localparam logic [4:0] CODE_MOV_REG = 5'b110_00;
   localparam logic [4:0] CODE_ADD     = 5'b101_00;
   localparam logic [4:0] CODE_CMP     = 5'b101_01;
   localparam logic [4:0] CODE_AND     = 5'b101_10;
   localparam logic [4:0] CODE_MVN     = 5'b101_11;

`ifdef SM_ILLEGAL_TRAP_EN
   localparam state_t ILLEGAL_DEST = ST_TRAP;
`else
   localparam state_t ILLEGAL_DEST = ST_WAIT;
`endif

   // Reset/idle output image: w high, every strobe low
   localparam ctrl_t CTRL_IDLE = ctrl_t'(14'b1_000_0000_00_00_0);

   state_t      state;
   state_t      next_state;
   logic [15:0] ir;
   logic [15:0] ir_next;
   logic        s_prev;
   logic        start;
   logic [4:0]  code;
   ctrl_t       ctrl;
   ctrl_t       ctrl_next;
   logic [2:0]  regnum_next;
   logic        err_next;

   function automatic logic is_legal(input logic [4:0] cd);
      case (cd)
         CODE_MOV_IMM, CODE_MOV_REG, CODE_ADD,
         CODE_CMP, CODE_AND, CODE_MVN: is_legal = 1'b1;
         default:                      is_legal = 1'b0;
      endcase
   endfunction

   // Moore strobe image for a given state; cd only refines EXEC
   function automatic ctrl_t ctrl_for(input state_t st, input logic [4:0] cd);
      ctrl_t c;
      c = ctrl_t'(14'b0);
      case (st)
         ST_WAIT: c.w = 1'b1;
         ST_GETA: begin
            c.nsel  = 3'b100;
            c.loada = 1'b1;
         end
         ST_GETB: begin
            c.nsel  = 3'b001;
            c.loadb = 1'b1;
         end
         ST_EXEC: begin
            c.loadc = 1'b1;
            c.asel  = (cd == CODE_MOV_REG) || (cd == CODE_MVN);
            c.loads = (cd == CODE_CMP);
         end
         ST_WREG: begin
            c.nsel  = 3'b010;
            c.vsel  = 2'b00;
            c.write = 1'b1;
         end
         ST_WIMM: begin
            c.nsel  = 3'b100;
            c.vsel  = 2'b10;
            c.write = 1'b1;
         end
         default: c = ctrl_t'(14'b0);
      endcase
      return c;
   endfunction

   // Register index picked by the one-hot nsel
   function automatic logic [2:0] reg_sel(input logic [2:0] sel, input logic [15:0] instr);
      case (sel)
         3'b001:  reg_sel = instr[2:0];
         3'b010:  reg_sel = instr[7:5];
         3'b100:  reg_sel = instr[10:8];
         default: reg_sel = 3'b000;
      endcase
   endfunction

   assign code = ir[15:11];

   // Start qualification: level or rising edge of s
   always_comb begin
      start = 1'b0;
      if (START_EDGE != 0) begin
         start = s & ~s_prev;
      end else begin
         start = s;
      end
   end

   // IR only accepts a new word while idle so a running instruction is safe
   always_comb begin
      ir_next = ir;
      if (load && (state == ST_WAIT)) begin
         ir_next = in;
      end else begin
         ir_next = ir;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         ST_WAIT: begin
            if (start) begin
               next_state = ST_DECODE;
            end else begin
               next_state = ST_WAIT;
            end
         end
         ST_DECODE: begin
            if (!is_legal(code)) begin
               next_state = ILLEGAL_DEST;
            end else begin
               case (code)
                  CODE_MOV_IMM: next_state = ST_WIMM;
                  CODE_MOV_REG: next_state = ST_GETB;
                  CODE_MVN:     next_state = ST_GETB;
                  default:      next_state = ST_GETA;
               endcase
            end
         end
         ST_GETA: next_state = ST_GETB;
         ST_GETB: next_state = ST_EXEC;
         ST_EXEC: begin
            if (code == CODE_CMP) begin
               next_state = ST_WAIT;
            end else begin
               next_state = ST_WREG;
            end
         end
         ST_WREG: next_state = ST_WAIT;
         ST_WIMM: next_state = ST_WAIT;
`ifdef SM_ILLEGAL_TRAP_EN
         ST_TRAP: next_state = ST_TRAP;
`else
         ST_TRAP: next_state = ST_WAIT;
`endif
         default: next_state = ST_WAIT;
      endcase
   end

   // Outputs are computed for the state being entered and registered, so the
   // registered copy always matches the Moore image of the current state.
   always_comb begin
      ctrl_next   = ctrl_for(next_state, ir_next[15:11]);
      regnum_next = reg_sel(ctrl_next.nsel, ir_next);
`ifdef SM_ILLEGAL_TRAP_EN
      err_next    = (next_state == ST_TRAP);
`else
      // err is high for the single WAIT cycle after an illegal decode
      err_next    = (state == ST_DECODE) && !is_legal(code);
`endif
   end

   // State, instruction register and start-edge history
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_WAIT;
         ir     <= 16'h0000;
         s_prev <= 1'b0;
      end else begin
         state  <= next_state;
         ir     <= ir_next;
         s_prev <= s;
      end
   end

   // Registered control outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl     <= CTRL_IDLE;
         readnum  <= 3'b000;
         writenum <= 3'b000;
         err      <= 1'b0;
      end else begin
         ctrl     <= ctrl_next;
         readnum  <= regnum_next;
         writenum <= regnum_next;
         err      <= err_next;
      end
   end

   assign w     = ctrl.w;
   assign nsel  = ctrl.nsel;
   assign loada = ctrl.loada;
   assign loadb = ctrl.loadb;
   assign loadc = ctrl.loadc;
   assign loads = ctrl.loads;
   assign asel  = ctrl.asel;
   assign bsel  = ctrl.bsel;
   assign vsel  = ctrl.vsel;
   assign write = ctrl.write;

   // Instruction-field outputs are straight wiring of the IR register
   assign ALUop  = ir[12:11];
   assign shift  = (code == CODE_MOV_IMM) ? 2'b00 : ir[4:3];
   assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
   assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_sm_controller.sv
// -----------------------------------------------------------------------------
// tb_sm_controller
//   Directed bench for sm_controller. Three instances share one stimulus:
//   m_ (DATA_W 16, level start), e_ (edge start), x_ (DATA_W 32).
// -----------------------------------------------------------------------------
module tb_sm_controller;

   logic        clk;
   logic        reset;
   logic        s;
   logic        load;
   logic [15:0] in;

   logic        m_w, m_err, m_loada, m_loadb, m_loadc, m_loads, m_asel, m_bsel, m_write;
   logic [2:0]  m_nsel, m_readnum, m_writenum;
   logic [1:0]  m_vsel, m_ALUop, m_shift;
   logic [15:0] m_sximm5, m_sximm8;

   logic        e_w, e_err, e_loada, e_loadb, e_loadc, e_loads, e_asel, e_bsel, e_write;
   logic [2:0]  e_nsel, e_readnum, e_writenum;
   logic [1:0]  e_vsel, e_ALUop, e_shift;
   logic [15:0] e_sximm5, e_sximm8;

   logic        x_w, x_err, x_loada, x_loadb, x_loadc, x_loads, x_asel, x_bsel, x_write;
   logic [2:0]  x_nsel, x_readnum, x_writenum;
   logic [1:0]  x_vsel, x_ALUop, x_shift;
   logic [31:0] x_sximm5, x_sximm8;

   int n_vec  = 0;
   int n_fail = 0;

   int          lat, cnt_a, cnt_b, cnt_c, cnt_s, cnt_w, asel_seen, sc_same;
   logic [2:0]  ra, rb, wn, wnsel;
   logic [1:0]  wv;
   logic [15:0] wimm;

   sm_controller #(.DATA_W(16), .START_EDGE(0)) u_main (
      .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
      .w(m_w), .err(m_err), .nsel(m_nsel), .readnum(m_readnum), .writenum(m_writenum),
      .loada(m_loada), .loadb(m_loadb), .loadc(m_loadc), .loads(m_loads),
      .asel(m_asel), .bsel(m_bsel), .vsel(m_vsel), .write(m_write),
      .ALUop(m_ALUop), .shift(m_shift), .sximm5(m_sximm5), .sximm8(m_sximm8));

   sm_controller #(.DATA_W(16), .START_EDGE(1)) u_edge (
      .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
      .w(e_w), .err(e_err), .nsel(e_nsel), .readnum(e_readnum), .writenum(e_writenum),
      .loada(e_loada), .loadb(e_loadb), .loadc(e_loadc), .loads(e_loads),
      .asel(e_asel), .bsel(e_bsel), .vsel(e_vsel), .write(e_write),
      .ALUop(e_ALUop), .shift(e_shift), .sximm5(e_sximm5), .sximm8(e_sximm8));

   sm_controller #(.DATA_W(32), .START_EDGE(0)) u_wide (
      .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
      .w(x_w), .err(x_err), .nsel(x_nsel), .readnum(x_readnum), .writenum(x_writenum),
      .loada(x_loada), .loadb(x_loadb), .loadc(x_loadc), .loads(x_loads),
      .asel(x_asel), .bsel(x_bsel), .vsel(x_vsel), .write(x_write),
      .ALUop(x_ALUop), .shift(x_shift), .sximm5(x_sximm5), .sximm8(x_sximm8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Time limit so the bench always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Load an instruction together with a one-cycle start, then track the
   // main instance until w returns (bounded at 20 edges).
   task automatic exec_instr(input logic [15:0] instr, input bit mid_load);
      in = instr; load = 1'b1; s = 1'b1;
      @(negedge clk);
      load = 1'b0; s = 1'b0;
      lat = 1; cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_s = 0; cnt_w = 0;
      asel_seen = 0; sc_same = 0;
      ra = 3'd7; rb = 3'd7; wn = 3'd7; wnsel = 3'd0; wv = 2'd3; wimm = 16'h0000;
      check("w_fall", m_w, 1'b0);
      if (mid_load) begin
         load = 1'b1; in = 16'hD3FF;
      end
      while (!m_w && lat < 20) begin
         if (m_loada) begin cnt_a++; ra = m_readnum; end
         if (m_loadb) begin cnt_b++; rb = m_readnum; end
         if (m_loadc) cnt_c++;
         if (m_loads) cnt_s++;
         if (m_loadc && m_loads) sc_same++;
         if (m_asel) asel_seen++;
         if (m_write) begin
            cnt_w++; wn = m_writenum; wnsel = m_nsel; wv = m_vsel; wimm = m_sximm8;
         end
         @(negedge clk);
         lat++;
      end
      load = 1'b0;
   endtask

   int m_wr, e_wr, first_wr, second_wr, bad;

   initial begin
      reset = 1'b0; s = 1'b0; load = 1'b0; in = 16'h0000;
      repeat (2) @(negedge clk);
      // Reset state
      check("rst_w", m_w, 1'b1);
      check("rst_err", m_err, 1'b0);
      check("rst_strobes", {m_loada, m_loadb, m_loadc, m_loads, m_asel, m_bsel, m_write}, 7'b0);
      check("rst_sel", {m_nsel, m_vsel, m_readnum, m_writenum}, 11'b0);
      reset = 1'b1;
      @(negedge clk);

      // MOV R2,#7 (load and s in the same cycle)
      exec_instr(16'hD207, 1'b0);
      check("movi_lat", lat, 3);
      check("movi_wr", cnt_w, 1);
      check("movi_nsel", wnsel, 3'b100);
      check("movi_wn", wn, 3'd2);
      check("movi_vsel", wv, 2'b10);
      check("movi_imm", wimm, 16'h0007);
      check("movi_noload", cnt_a + cnt_b + cnt_c, 0);

      // MOV R2,#-8: shift forced to 00 although ir[4:3] = 11
      exec_instr(16'hD2F8, 1'b0);
      check("movi_shift", m_shift, 2'b00);
      check("movi_alu", m_ALUop, 2'b10);
      check("movi_sx5", m_sximm5, 16'hFFF8);
      check("movi_sx8", m_sximm8, 16'hFFF8);

      // ADD R5,R0,R1
      exec_instr(16'hA0A1, 1'b0);
      check("add_lat", lat, 6);
      check("add_ra", {cnt_a[3:0], 1'b0, ra}, {4'd1, 1'b0, 3'd0});
      check("add_rb", {cnt_b[3:0], 1'b0, rb}, {4'd1, 1'b0, 3'd1});
      check("add_c", cnt_c, 1);
      check("add_loads", cnt_s, 0);
      check("add_asel", asel_seen, 0);
      check("add_wn", {cnt_w[3:0], 1'b0, wn}, {4'd1, 1'b0, 3'd5});
      check("add_wsel", {wnsel, wv}, {3'b010, 2'b00});

      // CMP R1,R1
      exec_instr(16'hA901, 1'b0);
      check("cmp_lat", lat, 5);
      check("cmp_sc", sc_same, 1);
      check("cmp_loads", cnt_s, 1);
      check("cmp_nowr", cnt_w, 0);

      // MVN R3,R2
      exec_instr(16'hB862, 1'b0);
      check("mvn_lat", lat, 5);
      check("mvn_noa", cnt_a, 0);
      check("mvn_asel", asel_seen, 1);
      check("mvn_rb", rb, 3'd2);
      check("mvn_wn", wn, 3'd3);

      // MOV R4,R3,LSL#1
      exec_instr(16'hC08B, 1'b0);
      check("movr_lat", lat, 5);
      check("movr_asel", asel_seen, 1);
      check("movr_rb", rb, 3'd3);
      check("movr_wn", wn, 3'd4);
      check("movr_shift", m_shift, 2'b01);

      // Sign extension to 32 bits
      exec_instr(16'hD2F0, 1'b0);
      check("sx8_16", m_sximm8, 16'hFFF0);
      check("sx8_32", x_sximm8, 32'hFFFF_FFF0);
      check("sx5_32", x_sximm5, 32'hFFFF_FFF0);

      // ADD with load asserted mid-sequence: ir must not change
      exec_instr(16'hA0A1, 1'b1);
      check("midld_lat", lat, 6);
      check("midld_wn", wn, 3'd5);
      check("midld_ir", m_sximm8, 16'hFFA1);

      // Reset during GETB
      in = 16'hA0A1; load = 1'b1; s = 1'b1;
      @(negedge clk);
      load = 1'b0; s = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("getb_loadb", m_loadb, 1'b1);
      reset = 1'b0;
      #1;
      check("abort_w", m_w, 1'b1);
      check("abort_strobes", {m_loada, m_loadb, m_loadc, m_loads, m_write, m_nsel}, 8'b0);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (m_write) bad++;
      end
      check("abort_nowr", bad, 0);
      reset = 1'b1;
      @(negedge clk);

      // s held high for 20 cycles on MOV imm
      in = 16'hD207; load = 1'b1;
      @(negedge clk);
      load = 1'b0; s = 1'b1;
      m_wr = 0; e_wr = 0; first_wr = -1; second_wr = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_write) begin
            m_wr++;
            if (first_wr < 0) first_wr = i;
            else if (second_wr < 0) second_wr = i;
         end
         if (e_write) e_wr++;
      end
      s = 1'b0;
      repeat (3) @(negedge clk);
      check("lvl_writes", m_wr, 7);
      check("lvl_period", second_wr - first_wr, 3);
      check("edge_writes", e_wr, 1);

      // Illegal instruction
      in = 16'hE000; load = 1'b1; s = 1'b1;
      @(negedge clk);
      load = 1'b0; s = 1'b0;
      check("ill_w_fall", m_w, 1'b0);
      check("ill_err0", m_err, 1'b0);
      @(negedge clk);
`ifdef SM_ILLEGAL_TRAP_EN
      check("trap_err", m_err, 1'b1);
      check("trap_w", m_w, 1'b0);
      bad = 0;
      in = 16'hD207;
      for (int i = 0; i < 12; i++) begin
         load = 1'b1; s = i[0];
         @(negedge clk);
         if (m_w || !m_err || m_write) bad++;
      end
      load = 1'b0; s = 1'b0;
      check("trap_hold", bad, 0);
`else
      check("ill_err", m_err, 1'b1);
      check("ill_w", m_w, 1'b1);
      @(negedge clk);
      check("ill_err_clr", m_err, 1'b0);
      check("ill_w_hold", m_w, 1'b1);
`endif
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("end_err", m_err, 1'b0);
      check("end_w", m_w, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/sm_controller.md
Name: sm_controller

Overview:
- Parametrised control unit for the Simple RISC Machine datapath: holds the instruction register, decodes fields, and sequences datapath load/select/write strobes through a multi-cycle Moore FSM.
- Next generation of the lab controller. Adds a generalised data width, busy-gated instruction load, selectable level/edge start, and an illegal-instruction flag.
- Sits between the top-level cpu wrapper (in/load/s/w) and the datapath (register file, A/B/C registers, shifter, ALU, status).

Parameters:
DATA_W, 16, datapath width; sximm5/sximm8 sign-extended to this; must be >= 16
START_EDGE, 0, 0 = start on s high in WAIT; 1 = start only on a rising s (s low in previous cycle)

Ports:
clk  input  1  clock, all state changes on rising edge
reset  input  1  asynchronous, active-low reset
s  input  1  start request
load  input  1  instruction register load enable
in  input  16  instruction word
w  output  1  1 = idle in WAIT, ready for s
err  output  1  illegal-instruction flag
nsel  output  3  one-hot register select: 001 Rm, 010 Rd, 100 Rn, 000 none
readnum  output  3  register-file read index
writenum  output  3  register-file write index
loada  output  1  load A register
loadb  output  1  load B register
loadc  output  1  load C register
loads  output  1  load status flags
asel  output  1  1 = ALU A input forced to zero
bsel  output  1  1 = ALU B input is sximm5
vsel  output  2  write-back mux: 00 C, 10 sximm8 (01, 11 reserved, never driven)
write  output  1  register-file write enable
ALUop  output  2  ir[12:11]
shift  output  2  ir[4:3]; forced to 00 for MOV immediate
sximm5  output  DATA_W  sign-extended ir[4:0]
sximm8  output  DATA_W  sign-extended ir[7:0]

Behaviour:
- Reset (reset low, asynchronous):
  - state = WAIT, ir = 0, err = 0, start-edge history = 0.
  - Outputs: w = 1; all strobes, nsel, vsel, readnum and writenum = 0.
  - Reset low mid-sequence aborts immediately. No write is issued after reset asserts.
- IR load: ir <= in on a clock edge when load = 1 and w = 1. load while w = 0 is ignored, so the current instruction cannot be corrupted.
- Decode fields:
  - opcode = ir[15:13], op = ir[12:11], Rn = ir[10:8], Rd = ir[7:5], Rm = ir[2:0].
  - readnum = writenum = the field selected by nsel; 0 when nsel = 000.
- Outputs are Moore, a function of state and ir only. Any strobe not listed for a state is 0.
- States and transitions:
  - WAIT: w = 1. Start condition true -> DECODE. Start condition is s (START_EDGE=0), or s & ~s_prev (START_EDGE=1). s_prev is sampled every cycle.
  - DECODE: no strobes. Branch on {opcode, op}:
    - 110_10 MOV imm -> WIMM
    - 110_00 MOV reg -> GETB
    - 101_00 ADD, 101_01 CMP, 101_10 AND -> GETA
    - 101_11 MVN -> GETB
    - any other code -> illegal handling (see Optional Feature)
  - GETA: nsel = 100, loada = 1 -> GETB.
  - GETB: nsel = 001, loadb = 1 -> EXEC.
  - EXEC: loadc = 1; asel = 1 for MOV reg and MVN; loads = 1 for CMP only. CMP -> WAIT; all others -> WREG.
  - WREG: nsel = 010, vsel = 00, write = 1 -> WAIT.
  - WIMM: nsel = 100, vsel = 10, write = 1 -> WAIT.
- Latency, counted in edges from the edge that samples start to the edge where w returns to 1:
  - MOV imm: 3
  - CMP: 5
  - MOV reg, MVN: 5
  - ADD, AND: 6
- w falls the cycle after start is sampled.
- s held high through a whole sequence:
  - START_EDGE=0: the same ir re-executes back-to-back, with one WAIT cycle between runs.
  - START_EDGE=1: executes once.
- load and s high in the same WAIT cycle: ir captures in, and the new instruction executes.

Optional Feature:
Macro SM_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal code in DECODE -> TRAP state: w = 0, err = 1, all strobes 0.
  - TRAP is left only by reset. s and load are ignored while in TRAP.
- Not defined:
  - An illegal code in DECODE -> WAIT with no strobes (executes as a no-op).
  - err pulses 1 for exactly the one WAIT cycle that follows.

Test Plan:
- Reset, then load = 1 with in = 16'hD207 (MOV R2,#7), then s = 1 for one cycle -> WIMM cycle shows nsel = 100, writenum = 2, vsel = 10, write = 1, sximm8 = 7; w = 1 three edges after start.
- Load 16'hA0A1 (ADD R5,R0,R1), then s -> loada with readnum = 0, then loadb with readnum = 1, then loadc, then write with writenum = 5; w returns after 6 edges; no loads pulse.
- Load 16'hA901 (CMP R1,R1) -> loads = 1 and loadc = 1 in EXEC, no write; w returns after 5 edges. With DATA_W = 32, load 16'hD2F0 -> sximm8 = 32'hFFFF_FFF0.
- Mid-ADD, assert load with in = 16'hD3FF -> ir unchanged, and ADD completes with writenum = 5. Pull reset low during GETB -> w = 1 and all strobes 0 immediately, with no write.
- Load 16'hE000 (illegal) and start -> with SM_ILLEGAL_TRAP_EN: err = 1 and w = 0 held for 10+ cycles until reset; without it: err pulses for one cycle, and w = 1 after 2 edges.
- START_EDGE = 1 with s held high for 20 cycles on MOV imm -> exactly one write pulse. START_EDGE = 0 under the same stimulus -> a write pulse every 3 cycles.
